// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receiver. Synchronizes rx_in, majority-votes each
// bit at mid-period, shifts data LSB-first, checks optional parity and the stop bit.
`timescale 1ns/1ps
module uart_rx_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                  state_q,      state_d;
    logic [1:0]              sync_q,       sync_d;
    logic [TICK_W-1:0]       tick_q,       tick_d;
    logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic [2:0]              samp_q,       samp_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic                    par_bad_q,    par_bad_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;

    logic rxs;
    logic decide;
    logic bit_val;
    logic par_exp;

    assign rxs     = sync_q[1];
    assign decide  = (tick_q == TICK_LAST);
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign par_exp = par_typ_q ? ~^shift_q : ^shift_q;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        sync_d       = {sync_q[0], rx_in};
        state_d      = state_q;
        tick_d       = tick_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        // Bit-period timing runs only while a frame is in flight.
        if (state_q != IDLE && state_q != WAIT_IDLE) begin
            tick_d = decide ? '0 : tick_q + TICK_W'(1);
            if (tick_q == TICK_S0) samp_d[0] = rxs;
            if (tick_q == TICK_S1) samp_d[1] = rxs;
            if (tick_q == TICK_S2) samp_d[2] = rxs;
        end

        case (state_q)
            IDLE: begin
                // This cycle is tick 0 of the start bit.
                if (!rxs) begin
                    state_d   = START;
                    tick_d    = TICK_W'(1);
                    bit_cnt_d = '0;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (decide) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = bit_val;
                    bit_cnt_d               = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bad_d = (bit_val != par_exp);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        if (par_bad_q) begin
                            par_err_d = 1'b1;
                        end else begin
                            p_data_d     = shift_q;
                            data_valid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        // Framing error: wait out a possible break before hunting again.
                        stp_err_d = 1'b1;
                        par_err_d = par_bad_q;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: table-driven frames, directed corner sequences,
// and randomized frames scored against a popcount-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int DW = 8;
    localparam int OS = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          rx_in   = 1'b1;
    logic          par_en  = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_deser #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } ev_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        logic          pbit;
        logic          sbit;
        int            gap;
        logic          dv;
        logic          perr;
        logic          serr;
        logic [DW-1:0] pdata;
    } vec_t;

    ev_t           exp_q[$];
    ev_t           obs_q[$];
    logic [DW-1:0] last_good = '0;
    int            n_checks  = 0;
    int            n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Record every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        ev_t ev;
        if (rst && (data_valid || par_err || stp_err)) begin
            ev.cyc  = cyc;
            ev.dv   = data_valid;
            ev.pe   = par_err;
            ev.se   = stp_err;
            ev.data = p_data;
            obs_q.push_back(ev);
            check("strobe_exclusive", 32'(data_valid && (par_err || stp_err)), 32'd0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        wait_cycles(n);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        wait_cycles(OS);
    endtask

    // Drives one frame; strobe_cyc is when its outcome strobe must be seen:
    // first sampling edge is cyc+1, two synchronizer edges, then N bit periods.
    task automatic send_frame(input logic [DW-1:0] data, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, output int strobe_cyc);
        int nbits;
        nbits      = 2 + DW + int'(pe);
        par_en     = pe;
        par_typ    = pt;
        strobe_cyc = cyc + 2 + nbits * OS;
        drive_bit(1'b0);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        for (int i = 0; i < DW; i++) drive_bit(data[i]);
        if (pe) drive_bit(pbit);
        drive_bit(sbit);
    endtask

    function automatic ev_t model(input int c, input logic [DW-1:0] data, input logic pe,
                                  input logic pt, input logic pbit, input logic sbit);
        ev_t e;
        bit  par_ok;
        par_ok = !pe || ((($countones(data) + int'(pbit)) % 2) == int'(pt));
        e.cyc  = c;
        e.dv   = sbit && par_ok;
        e.pe   = !par_ok;
        e.se   = !sbit;
        e.data = e.dv ? data : last_good;
        return e;
    endfunction

    task automatic push_exp(input int c, input logic dv, input logic pe, input logic se,
                            input logic [DW-1:0] d);
        ev_t e;
        e.cyc  = c;
        e.dv   = dv;
        e.pe   = pe;
        e.se   = se;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string tag);
        ev_t e;
        ev_t o;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_cycle"}, 32'(o.cyc), 32'(e.cyc));
            check({tag, "_kind"}, {29'd0, o.dv, o.pe, o.se}, {29'd0, e.dv, e.pe, e.se});
            check({tag, "_p_data"}, 32'(o.data), 32'(e.data));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int   sc;
        int   gap;
        ev_t  e;
        logic [DW-1:0] d;
        logic pe, pt, pbit, sbit;

        // data, par_en, par_typ, par_bit, stop_bit, gap, expect dv/par_err/stp_err, p_data
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'h55};
        // 0xA3 has four ones, so odd parity needs a 1 in the parity slot.
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 5,  1'b0, 1'b1, 1'b0, 8'h55};
        vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'hA3};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b1, 1'b1, 8'hA3};
        vecs[4] = '{8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'h96};
        vecs[5] = '{8'hE7, 1'b1, 1'b0, 1'b1, 1'b1, 3,  1'b0, 1'b1, 1'b0, 8'h96};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b0, 8'h00};

        // Reset state
        wait_cycles(3);
        check("reset_p_data", 32'(p_data), 32'd0);
        check("reset_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        rst = 1'b1;
        idle(10);

        // Table-driven frames, including a back-to-back pair and a parity+stop error.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit, sc);
            push_exp(sc, vecs[i].dv, vecs[i].perr, vecs[i].serr, vecs[i].pdata);
            if (vecs[i].dv) last_good = vecs[i].data;
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        idle(30);
        compare("table");

        // Break: stop bit low then line held low for 40 bit periods.
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, sc);
        push_exp(sc, 1'b0, 1'b0, 1'b1, last_good);
        wait_cycles(40 * OS);
        idle(2 * OS);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, sc);
        push_exp(sc, 1'b1, 1'b0, 1'b0, 8'h3C);
        last_good = 8'h3C;
        idle(30);
        compare("break");

        // Three-cycle glitch on an idle line must produce nothing.
        rx_in = 1'b0;
        wait_cycles(3);
        idle(40);
        compare("glitch");

        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, sc);
        push_exp(sc, 1'b1, 1'b0, 1'b0, 8'h01);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, sc);
        push_exp(sc, 1'b1, 1'b0, 1'b0, 8'hFF);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, sc);
        push_exp(sc, 1'b1, 1'b0, 1'b0, 8'h80);
        last_good = 8'h80;
        idle(30);
        if (obs_q.size() >= 3) begin
            check("b2b_spacing_1", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd80);
            check("b2b_spacing_2", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'd80);
        end
        compare("b2b");

        // Reset in the middle of the data bits.
        d      = 8'hC6;
        par_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        wait_cycles(OS / 2);
        rst = 1'b0;
        #1;
        check("midreset_p_data", 32'(p_data), 32'd0);
        check("midreset_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        wait_cycles(3);
        rx_in = 1'b1;
        wait_cycles(2);
        rst       = 1'b1;
        last_good = '0;
        idle(20);
        compare("midreset_partial");
        send_frame(8'hC6, 1'b0, 1'b0, 1'b0, 1'b1, sc);
        push_exp(sc, 1'b1, 1'b0, 1'b0, 8'hC6);
        last_good = 8'hC6;
        idle(30);
        compare("after_reset");

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            d    = DW'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            pbit = 1'($urandom);
            sbit = ($urandom_range(0, 4) != 0);
            send_frame(d, pe, pt, pbit, sbit, sc);
            e = model(sc, d, pe, pt, pbit, sbit);
            exp_q.push_back(e);
            if (e.dv) last_good = d;
            gap = sbit ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 20));
            if (gap > 0) idle(gap);
        end
        idle(30);
        compare("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
